tw_msg_merger: RTL and testbench



---
 rtl/tw_msg_merger_pkg.sv | 53 +++++
 rtl/tw_msg_merger_if.sv | 31 +++
 rtl/tw_out_reg.sv | 72 +++++++
 rtl/tw_msg_merger.sv | 164 ++++++++++++++++
 tb/tb_tw_msg_merger.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tw_msg_merger_pkg.sv
// -----------------------------------------------------------------------------
// tw_msg_merger_pkg
// Constants shared with the OmpSs manager (header TYPE bit, components field,
// accelerator-id width), plus the merger's state/source types and the header
// rewrite helper.
// -----------------------------------------------------------------------------
package tw_msg_merger_pkg;

  // Header layout of a Taskwait inStream message (beat 0).
  localparam int TYPE_B                = 0;
  localparam int INSTREAM_COMPONENTS_L = 32;
  localparam int INSTREAM_COMPONENTS_H = 39;

  // Number of meaningful bits in the 4-bit TID field.
  localparam int ACC_BITS              = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_TID
  } state_e;

  // Encoding doubles as the protoErr bit index of each source.
  typedef enum logic {
    SRC_ACC = 1'b0,
    SRC_FIN = 1'b1
  } src_e;

  // Accelerator requests are tagged TYPE=1 and keep their component count;
  // finish notifications are tagged TYPE=0 and carry no components.
  function automatic logic [63:0] rewrite_header(input logic [63:0] hdr,
                                                 input src_e        src);
    logic [63:0] r;
    r = hdr;
    if (src == SRC_ACC) begin
      r[TYPE_B] = 1'b1;
    end else begin
      r[TYPE_B] = 1'b0;
      r[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = '0;
    end
    return r;
  endfunction

  // Mask keeping the low acc_bits of a 4-bit TID.
  function automatic logic [3:0] tid_mask(input int acc_bits);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i] = (i < acc_bits);
    end
    return m;
  endfunction

endpackage

// File: rtl/tw_msg_merger_if.sv
// -----------------------------------------------------------------------------
// tw_msg_merger_if
// One AXI-Stream link: 64-bit TDATA, 4-bit TID, TLAST, valid/ready.
//   master : drives TDATA/TVALID/TID/TLAST, samples TREADY
//   slave  : samples TDATA/TVALID/TID/TLAST, drives TREADY
// -----------------------------------------------------------------------------
interface tw_msg_merger_if;

  logic [63:0] TDATA;
  logic        TVALID;
  logic [3:0]  TID;
  logic        TLAST;
  logic        TREADY;

  modport master (
    output TDATA,
    output TVALID,
    output TID,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TVALID,
    input  TID,
    input  TLAST,
    output TREADY
  );

endinterface

// File: rtl/tw_out_reg.sv
// -----------------------------------------------------------------------------
// tw_out_reg
// One-entry AXI-Stream output register. A beat is captured whenever the slot
// is empty or is being drained in the same cycle, so back-to-back beats flow
// at full rate while the downstream is ready.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake (in_ready is combinational)
//   in_data/id/last    upstream beat payload
//   out_if             registered AXI-Stream master towards the consumer
// -----------------------------------------------------------------------------
module tw_out_reg (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  input  logic [3:0]             in_id,
  input  logic                   in_last,
  tw_msg_merger_if.master        out_if
);

  logic        valid_q, valid_d;
  logic [63:0] data_q,  data_d;
  logic [3:0]  id_q,    id_d;
  logic        last_q,  last_d;
  logic        load;

  // NOTE: combinational next-state uses blocking '=' in always_comb; the flop
  // process below uses non-blocking '<=' only, so flop-to-flop order never
  // depends on simulator scheduling.
  always_comb begin
    // NOTE: every signal written here gets its default first; a path that left
    // one unassigned would infer a latch.
    in_ready = !valid_q || out_if.TREADY;
    load     = in_valid && in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    id_d     = id_q;
    last_d   = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      id_d    = in_id;
      last_d  = in_last;
    end else if (out_if.TREADY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      // NOTE: the payload registers are reset as well: the consumer sees an
      // all-zero TDATA/TID out of reset, not just a low TVALID.
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign out_if.TVALID = valid_q;
  assign out_if.TDATA  = data_q;
  assign out_if.TID    = id_q;
  assign out_if.TLAST  = last_q;

endmodule

// File: rtl/tw_msg_merger.sv
// -----------------------------------------------------------------------------
// tw_msg_merger
// Merges two 2-beat message sources (accelerator taskwait requests and child
// task finish notifications) into one registered AXI-Stream feeding the
// Taskwait inStream. Packets are never interleaved: the grant is taken in IDLE
// and held through the header (HDR) and task-id (TID) beats. Ties alternate,
// starting with the accelerator source after reset.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   twReq       accelerator taskwait requests (slave)
//   twFin       task finish notifications (slave)
//   outStream   merged stream to Taskwait (master, registered)
//   protoErr    sticky TLAST violation flags, bit0 = twReq, bit1 = twFin
// -----------------------------------------------------------------------------
module tw_msg_merger #(
  parameter int ACC_BITS = tw_msg_merger_pkg::ACC_BITS
) (
  input  logic             clk,
  input  logic             rstn,
  tw_msg_merger_if.slave   twReq,
  tw_msg_merger_if.slave   twFin,
  tw_msg_merger_if.master  outStream,
  output logic [1:0]       protoErr
);

  import tw_msg_merger_pkg::*;

  localparam logic [3:0] TID_MASK = tid_mask(ACC_BITS);

  state_e      state_q,       state_d;
  src_e        grant_q,       grant_d;
  src_e        last_served_q, last_served_d;
  logic [3:0]  hdr_tid_q,     hdr_tid_d;
  logic [1:0]  perr_q,        perr_d;

  // Granted source, muxed once so the FSM and datapath see a single stream.
  logic        sel_valid;
  logic [63:0] sel_data;
  logic [3:0]  sel_tid;
  logic        sel_last;

  logic        busy;
  logic        beat_valid;
  logic        beat_ready;
  logic        beat_hs;
  logic [63:0] beat_data;
  logic [3:0]  beat_id;
  logic        beat_last;

  always_comb begin
    if (grant_q == SRC_FIN) begin
      sel_valid = twFin.TVALID;
      sel_data  = twFin.TDATA;
      sel_tid   = twFin.TID;
      sel_last  = twFin.TLAST;
    end else begin
      sel_valid = twReq.TVALID;
      sel_data  = twReq.TDATA;
      sel_tid   = twReq.TID;
      sel_last  = twReq.TLAST;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign beat_valid = busy && sel_valid;
  assign beat_hs    = beat_valid && beat_ready;

  // beat_ready already folds in outStream_TREADY, so a stalled output register
  // blocks both sources in the same cycle.
  assign twReq.TREADY = busy && beat_ready && (grant_q == SRC_ACC);
  assign twFin.TREADY = busy && beat_ready && (grant_q == SRC_FIN);

  // ---------------------------------------------------------------------------
  // Beat payload: header rewritten by source, task id passed through. Both
  // output beats carry the TID sampled with the header.
  // ---------------------------------------------------------------------------
  always_comb begin
    beat_data = sel_data;
    beat_id   = hdr_tid_q;
    beat_last = 1'b0;
    if (state_q == ST_HDR) begin
      beat_data = rewrite_header(sel_data, grant_q);
      beat_id   = sel_tid & TID_MASK;
    end else if (state_q == ST_TID) begin
      beat_last = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, arbiter and TLAST checker
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    hdr_tid_d     = hdr_tid_q;
    perr_d        = perr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (twReq.TVALID || twFin.TVALID) begin
          state_d = ST_HDR;
          if (twReq.TVALID && twFin.TVALID) begin
            grant_d = (last_served_q == SRC_ACC) ? SRC_FIN : SRC_ACC;
          end else if (twReq.TVALID) begin
            grant_d = SRC_ACC;
          end else begin
            grant_d = SRC_FIN;
          end
        end
      end
      ST_HDR: begin
        if (beat_hs) begin
          state_d   = ST_TID;
          hdr_tid_d = sel_tid & TID_MASK;
          // The packet is forwarded by position even when TLAST is wrong.
          if (sel_last) begin
            perr_d[grant_q] = 1'b1;
          end
        end
      end
      ST_TID: begin
        if (beat_hs) begin
          state_d       = ST_IDLE;
          last_served_d = grant_q;
          if (!sel_last) begin
            perr_d[grant_q] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      grant_q       <= SRC_ACC;
      // Starting from FIN makes the accelerator win the first tie.
      last_served_q <= SRC_FIN;
      hdr_tid_q     <= '0;
      perr_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      hdr_tid_q     <= hdr_tid_d;
      perr_q        <= perr_d;
    end
  end

  assign protoErr = perr_q;

  tw_out_reg u_out_reg (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (beat_valid),
    .in_ready (beat_ready),
    .in_data  (beat_data),
    .in_id    (beat_id),
    .in_last  (beat_last),
    .out_if   (outStream)
  );

endmodule

// File: tb/tb_tw_msg_merger.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tw_msg_merger
// Drives packets on twReq/twFin, collects accepted output beats and compares
// them against beats predicted from the message rules (header rewrite, TID
// from the header, packet order from the alternating tie rule).
// -----------------------------------------------------------------------------
module tb_tw_msg_merger;

  import tw_msg_merger_pkg::*;

  localparam int CW = INSTREAM_COMPONENTS_H - INSTREAM_COMPONENTS_L + 1;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
  } beat_t;

  typedef struct {
    bit          fin;
    logic [63:0] hdr;
    logic [63:0] tid;
    logic [3:0]  id0;
    logic [3:0]  id1;
    logic        last0;
    logic        last1;
  } pkt_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] protoErr;

  tw_msg_merger_if twReq ();
  tw_msg_merger_if twFin ();
  tw_msg_merger_if outStream ();

  tw_msg_merger #(.ACC_BITS(ACC_BITS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .twReq     (twReq),
    .twFin     (twFin),
    .outStream (outStream),
    .protoErr  (protoErr)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  bit    model_last_fin = 1'b1;

  // Every accepted output beat, captured half a cycle before its edge.
  always @(negedge clk) begin
    if (rstn && outStream.TVALID && outStream.TREADY) begin
      got_q.push_back({outStream.TDATA, outStream.TID});
    end
  end

  // ---------------------------------------------------------------- model ---
  task automatic expect_pkt(input pkt_t p);
    beat_t h;
    h.data = p.hdr;
    if (p.fin) begin
      h.data[TYPE_B] = 1'b0;
      h.data[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = '0;
    end else begin
      h.data[TYPE_B] = 1'b1;
    end
    h.id = p.id0 & 4'((1 << ACC_BITS) - 1);
    exp_q.push_back(h);
    exp_q.push_back({p.tid, h.id});
    model_last_fin = p.fin;
  endtask

  function automatic pkt_t rand_pkt(input bit fin);
    pkt_t p;
    p.fin   = fin;
    p.hdr   = {$urandom, $urandom};
    p.tid   = {$urandom, $urandom};
    p.id0   = 4'($urandom_range(0, 15));
    p.id1   = 4'($urandom_range(0, 15));
    p.last0 = 1'b0;
    p.last1 = 1'b1;
    return p;
  endfunction

  // --------------------------------------------------------------- drivers ---
  task automatic drive(input bit fin, input logic v, input logic [63:0] d,
                       input logic [3:0] id, input logic l);
    if (fin) begin
      twFin.TVALID = v; twFin.TDATA = d; twFin.TID = id; twFin.TLAST = l;
    end else begin
      twReq.TVALID = v; twReq.TDATA = d; twReq.TID = id; twReq.TLAST = l;
    end
  endtask

  // Presents both beats back to back, each held until accepted.
  task automatic send_pkt(input pkt_t p);
    for (int b = 0; b < 2; b++) begin
      bit hs;
      hs = 1'b0;
      drive(p.fin, 1'b1, (b == 0) ? p.hdr : p.tid, (b == 0) ? p.id0 : p.id1,
            (b == 0) ? p.last0 : p.last1);
      for (int c = 0; c < 200 && !hs; c++) begin
        @(negedge clk);
        hs = p.fin ? twFin.TREADY : twReq.TREADY;
        @(posedge clk); #1;
      end
      if (!hs) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout src=%0d beat=%0d never accepted", p.fin, b);
      end
    end
    drive(p.fin, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int c = 0; c < 200 && !empty; c++) begin
      @(negedge clk);
      empty = !outStream.TVALID;
    end
    if (!empty) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout outStream_TVALID still 1, required 0");
    end
    @(posedge clk); #1;
  endtask

  // ----------------------------------------------------------------- tests ---
  task automatic test_reset();
    outStream.TREADY = 1'b1;
    drive(1'b0, 1'b1, 64'h1, 4'h1, 1'b0);
    drive(1'b1, 1'b1, 64'h2, 4'h2, 1'b0);
    #12;
    n_tests += 6;
    if (outStream.TVALID !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b required 0", outStream.TVALID); end
    if (outStream.TDATA !== 64'h0) begin n_fail++; $display("FAIL rst_tdata got %h required 0", outStream.TDATA); end
    if (outStream.TID !== 4'h0) begin n_fail++; $display("FAIL rst_tid got %h required 0", outStream.TID); end
    if (twReq.TREADY !== 1'b0) begin n_fail++; $display("FAIL rst_req_tready got %b required 0", twReq.TREADY); end
    if (twFin.TREADY !== 1'b0) begin n_fail++; $display("FAIL rst_fin_tready got %b required 0", twFin.TREADY); end
    if (protoErr !== 2'b00) begin n_fail++; $display("FAIL rst_protoerr got %b required 00", protoErr); end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_acc_basic();
    pkt_t p;
    int   lat;
    lat = -1;
    p = rand_pkt(1'b0);
    p.hdr[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = CW'(3);
    p.hdr[TYPE_B] = 1'b0;
    p.id0 = 4'd2;
    p.tid = 64'hAB;
    expect_pkt(p);
    fork
      send_pkt(p);
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (outStream.TVALID) begin lat = c; break; end
        end
      end
    join
    drain();
    n_tests++;
    if (lat != 2) begin n_fail++; $display("FAIL acc_latency got %0d cycles required 2", lat); end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL acc_beats got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL acc_beat%0d got %h/%h required %h/%h", i, got_q[i].data, got_q[i].id, exp_q[i].data, exp_q[i].id); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_fin_basic();
    pkt_t p;
    p = rand_pkt(1'b1);
    p.hdr[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = CW'(5);
    p.hdr[TYPE_B] = 1'b1;
    p.id0 = 4'd7;
    p.id1 = 4'd4;
    expect_pkt(p);
    send_pkt(p);
    drain();
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fin_beats got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fin_beat%0d got %h/%h required %h/%h", i, got_q[i].data, got_q[i].id, exp_q[i].data, exp_q[i].id); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // Both sources keep a packet pending at all times: ties alternate.
  task automatic test_alternate();
    pkt_t req[4];
    pkt_t fin[4];
    int   a, f;
    bit   pick_fin;
    foreach (req[i]) req[i] = rand_pkt(1'b0);
    foreach (fin[i]) fin[i] = rand_pkt(1'b1);
    a = 0; f = 0;
    while (a < 4 || f < 4) begin
      pick_fin = (a < 4 && f < 4) ? !model_last_fin : (f < 4);
      if (pick_fin) begin expect_pkt(fin[f]); f++; end
      else begin expect_pkt(req[a]); a++; end
    end
    fork
      begin for (int i = 0; i < 4; i++) send_pkt(req[i]); end
      begin for (int i = 0; i < 4; i++) send_pkt(fin[i]); end
    join
    drain();
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL alt_beats got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL alt_beat%0d got %h/%h required %h/%h", i, got_q[i].data, got_q[i].id, exp_q[i].data, exp_q[i].id); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    pkt_t  pr, pf;
    beat_t held;
    bit    seen;
    pr = rand_pkt(1'b0);
    pf = rand_pkt(1'b1);
    seen = 1'b0;
    held = '0;
    if (model_last_fin) begin expect_pkt(pr); expect_pkt(pf); end
    else begin expect_pkt(pf); expect_pkt(pr); end
    outStream.TREADY = 1'b0;
    fork
      send_pkt(pr);
      send_pkt(pf);
      begin
        for (int c = 0; c < 50 && !seen; c++) begin
          @(negedge clk);
          seen = outStream.TVALID;
        end
        held = {outStream.TDATA, outStream.TID};
        if (!seen) begin n_tests++; n_fail++; $display("FAIL bp_timeout no output beat appeared"); end
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          n_tests++;
          if (outStream.TVALID !== 1'b1 || {outStream.TDATA, outStream.TID} !== held ||
              twReq.TREADY !== 1'b0 || twFin.TREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d got v=%b %h/%h rdy=%b%b required v=1 %h/%h rdy=00",
                     c, outStream.TVALID, outStream.TDATA, outStream.TID,
                     twReq.TREADY, twFin.TREADY, held.data, held.id);
          end
        end
        @(posedge clk); #1;
        outStream.TREADY = 1'b1;
      end
    join
    drain();
    n_tests++;
    if (held !== exp_q[0]) begin n_fail++; $display("FAIL bp_held got %h/%h required %h/%h", held.data, held.id, exp_q[0].data, exp_q[0].id); end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_beats got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat%0d got %h/%h required %h/%h", i, got_q[i].data, got_q[i].id, exp_q[i].data, exp_q[i].id); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_proto_err();
    pkt_t bad, g1, g2, badf;
    bit   hs;
    hs  = 1'b0;
    bad = rand_pkt(1'b0);
    bad.last0 = 1'b1;
    g1 = rand_pkt(1'b0);
    g2 = rand_pkt(1'b1);
    badf = rand_pkt(1'b1);
    badf.last1 = 1'b0;
    expect_pkt(bad);
    fork
      send_pkt(bad);
      begin
        for (int c = 0; c < 50 && !hs; c++) begin
          @(negedge clk);
          hs = twReq.TVALID && twReq.TREADY;
        end
        n_tests++;
        if (!hs || protoErr !== 2'b00) begin n_fail++; $display("FAIL perr_before got %b hs=%b required 00 hs=1", protoErr, hs); end
        @(negedge clk);
        n_tests++;
        if (protoErr !== 2'b01) begin n_fail++; $display("FAIL perr_set got %b required 01", protoErr); end
      end
    join
    drain();
    expect_pkt(g1);
    send_pkt(g1);
    expect_pkt(g2);
    send_pkt(g2);
    drain();
    n_tests++;
    if (protoErr !== 2'b01) begin n_fail++; $display("FAIL perr_sticky got %b required 01", protoErr); end
    expect_pkt(badf);
    send_pkt(badf);
    drain();
    n_tests++;
    if (protoErr !== 2'b11) begin n_fail++; $display("FAIL perr_fin got %b required 11", protoErr); end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL perr_beats got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL perr_beat%0d got %h/%h required %h/%h", i, got_q[i].data, got_q[i].id, exp_q[i].data, exp_q[i].id); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    pkt_t p, pr, pf;
    bit   seen;
    seen = 1'b0;
    p = rand_pkt(1'b0);
    outStream.TREADY = 1'b0;
    drive(1'b0, 1'b1, p.hdr, p.id0, 1'b0);
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = outStream.TVALID;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_timeout header never reached outStream"); end
    drive(1'b0, 1'b1, p.tid, p.id1, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    n_tests += 4;
    if (outStream.TVALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got %b required 0", outStream.TVALID); end
    if (outStream.TDATA !== 64'h0) begin n_fail++; $display("FAIL rstmid_tdata got %h required 0", outStream.TDATA); end
    if (twReq.TREADY !== 1'b0 || twFin.TREADY !== 1'b0) begin n_fail++; $display("FAIL rstmid_tready got %b%b required 00", twReq.TREADY, twFin.TREADY); end
    if (protoErr !== 2'b00) begin n_fail++; $display("FAIL rstmid_protoerr got %b required 00", protoErr); end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    got_q.delete(); exp_q.delete();
    model_last_fin = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    outStream.TREADY = 1'b1;
    @(posedge clk); #1;
    // First tie after reset goes to the accelerator.
    pr = rand_pkt(1'b0);
    pf = rand_pkt(1'b1);
    expect_pkt(pr);
    expect_pkt(pf);
    fork
      send_pkt(pr);
      send_pkt(pf);
    join
    drain();
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_beats got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_beat%0d got %h/%h required %h/%h", i, got_q[i].data, got_q[i].id, exp_q[i].data, exp_q[i].id); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // One packet at a time from a random source, random output stalls.
  task automatic test_random();
    pkt_t p[12];
    bit   done;
    done = 1'b0;
    foreach (p[i]) begin
      p[i] = rand_pkt(1'($urandom_range(0, 1)));
      expect_pkt(p[i]);
    end
    fork
      begin
        for (int i = 0; i < 12; i++) send_pkt(p[i]);
        done = 1'b1;
      end
      begin
        while (!done) begin
          outStream.TREADY = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    outStream.TREADY = 1'b1;
    drain();
    n_tests++;
    if (protoErr !== 2'b00) begin n_fail++; $display("FAIL rand_protoerr got %b required 00", protoErr); end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_beats got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_beat%0d got %h/%h required %h/%h", i, got_q[i].data, got_q[i].id, exp_q[i].data, exp_q[i].id); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_acc_basic();
    test_fin_basic();
    test_alternate();
    test_backpressure();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
